// File: rtl/cmp_seq_multibyte.sv
// cmp_seq_multibyte: byte-serial MSB-first wide magnitude compare via external 8-bit comparator; `define SIGNED_CMP_EN for two's complement
module cmp_seq_multibyte #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [8*BYTES-1:0] op_a,
  input  logic [8*BYTES-1:0] op_b,
  output logic               busy,
  output logic               done,
  output logic               res_gt,
  output logic               res_eq,
  output logic               res_lt,
  output logic               err,
  output logic [7:0]         cmp_a,
  output logic [7:0]         cmp_b,
  input  logic               cmp_gt,
  input  logic               cmp_eq,
  input  logic               cmp_lt
);
  localparam int IW = BYTES > 1 ? $clog2(BYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [8*BYTES-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]         res_q, res_d;
  logic               err_q, err_d;
  logic [2:0]         flags;
  logic               one_hot, run;
  logic [7:0]         byte_a, byte_b;
  assign run     = state_q == RUN;
  assign byte_a  = a_q[{idx_q, 3'b000} +: 8];
  assign byte_b  = b_q[{idx_q, 3'b000} +: 8];
  assign flags   = {cmp_gt, cmp_eq, cmp_lt};
  assign one_hot = flags == 3'b100 || flags == 3'b010 || flags == 3'b001;
`ifdef SIGNED_CMP_EN
  logic [7:0] flip;
  // Flipping the sign bit of the top byte maps two's complement order onto unsigned order
  assign flip  = idx_q == IW'(BYTES-1) ? 8'h80 : 8'h00;
  assign cmp_a = run ? byte_a ^ flip : 8'h00;
  assign cmp_b = run ? byte_b ^ flip : 8'h00;
`else
  assign cmp_a = run ? byte_a : 8'h00;
  assign cmp_b = run ? byte_b : 8'h00;
`endif
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = op_a;
        b_d     = op_b;
        idx_d   = IW'(BYTES-1);
        state_d = RUN;
      end
      RUN: if (!one_hot) begin
        res_d   = 3'b000;
        err_d   = 1'b1;
        state_d = DONE;
      end else if (cmp_eq && idx_q != '0) begin
        idx_d = idx_q - 1'b1;
      end else begin
        res_d   = flags;
        err_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = state_q == DONE;
  assign res_gt = res_q[2];
  assign res_eq = res_q[1];
  assign res_lt = res_q[0];
  assign err    = err_q;
endmodule

// File: tb/tb_cmp_seq_multibyte.sv
// tb_cmp_seq_multibyte: directed vector table plus handshake, reset, fault and back-to-back sequences
module tb_cmp_seq_multibyte;
  logic        clk = 0, rst_n = 0, start = 0, fault = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic        busy, done, res_gt, res_eq, res_lt, err;
  logic [7:0]  cmp_a, cmp_b;
  logic        cmp_gt, cmp_eq, cmp_lt;
  int          n_cmp = 0, n_bad = 0;

  cmp_seq_multibyte #(.BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt),
    .err(err), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt)
  );

  always #5 clk = ~clk;

  assign cmp_gt = fault ? 1'b1 : cmp_a > cmp_b;
  assign cmp_lt = fault ? 1'b1 : cmp_a < cmp_b;
  assign cmp_eq = fault ? 1'b0 : cmp_a == cmp_b;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  res;
    int          cyc;
    logic [7:0]  first_a;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_cmp(input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [7:0] first_a);
    op_a  = a;
    op_b  = b;
    start = 1;
    tick();
    start   = 0;
    first_a = cmp_a;
    cyc     = 1;
    while (!done && cyc < 12) begin
      tick();
      cyc++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no done within %0d cycles", cyc);
    end
  endtask

  task automatic finish_cmp();
    tick();
  endtask

  vec_t vecs[7];
  int         cyc, dn;
  logic [7:0] fa;

  initial begin
    vecs[0] = '{32'h12345678, 32'h12345678, 3'b010, 5, 8'h12};
`ifdef SIGNED_CMP_EN
    vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 3'b001, 2, 8'h00};
`else
    vecs[1] = '{32'h80000000, 32'h7FFFFFFF, 3'b100, 2, 8'h80};
`endif
    vecs[2] = '{32'h000000FE, 32'h000000FF, 3'b001, 5, 8'h00};
    vecs[3] = '{32'h00010000, 32'h00000000, 3'b100, 3, 8'h00};
`ifdef SIGNED_CMP_EN
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 3'b100, 5, 8'h7F};
`else
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 3'b100, 5, 8'hFF};
`endif
    vecs[5] = '{32'h00000000, 32'h00000000, 3'b010, 5, 8'h00};
    vecs[6] = '{32'h12003456, 32'h12010000, 3'b001, 3, 8'h12};

    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_res", {res_gt, res_eq, res_lt}, 0);
    chk("reset_err", err, 0);
    chk("idle_cmp_a", cmp_a, 0);
    rst_n = 1;
    tick();

    foreach (vecs[i]) begin
      do_cmp(vecs[i].a, vecs[i].b, cyc, fa);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].cyc);
      chk($sformatf("v%0d_first_a", i), fa, vecs[i].first_a);
      chk($sformatf("v%0d_res", i), {res_gt, res_eq, res_lt}, vecs[i].res);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_busy", i), busy, 1);
      finish_cmp();
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
    end

    // start during RUN ignored; operand change after acceptance has no effect
    op_a = 32'h000000FE; op_b = 32'h000000FF; start = 1;
    tick();
    start = 0;
    tick();
    start = 1; op_a = 32'hFFFFFFFF;
    tick();
    start = 0;
    cyc = 3;
    while (!done && cyc < 12) begin tick(); cyc++; end
    chk("ign_cycles", cyc, 5);
    chk("ign_res", {res_gt, res_eq, res_lt}, 3'b001);
    dn = 0;
    for (int i = 0; i < 8; i++) begin tick(); dn += done; end
    chk("ign_no_second_done", dn, 0);

    // asynchronous reset in the 2nd RUN cycle
    op_a = 32'h12345678; op_b = 32'h12345678; start = 1;
    tick();
    start = 0;
    tick();
    chk("rst_pre_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {res_gt, res_eq, res_lt}, 0);
    chk("rst_err", err, 0);
    chk("rst_cmp_a", cmp_a, 0);
    tick();
    rst_n = 1;
    tick();
    do_cmp(32'h12345678, 32'h12345678, cyc, fa);
    chk("post_rst_cycles", cyc, 5);
    chk("post_rst_res", {res_gt, res_eq, res_lt}, 3'b010);
    finish_cmp();

    // comparator fault on first byte
    fault = 1;
    do_cmp(32'h11111111, 32'h22222222, cyc, fa);
    fault = 0;
    chk("fault_cycles", cyc, 2);
    chk("fault_err", err, 1);
    chk("fault_res", {res_gt, res_eq, res_lt}, 0);
    finish_cmp();
    chk("fault_err_held", err, 1);
    do_cmp(32'h00000005, 32'h00000003, cyc, fa);
    chk("recover_err", err, 0);
    chk("recover_res", {res_gt, res_eq, res_lt}, 3'b100);
    finish_cmp();

    // start held high: one accepted compare every 3 cycles
    op_a = 32'h01000000; op_b = 32'h02000000; start = 1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk($sformatf("b2b_done_t%0d", t), done, t % 3 == 2);
      chk($sformatf("b2b_busy_t%0d", t), busy, t % 3 != 0);
      if (t % 3 == 2) chk($sformatf("b2b_res_t%0d", t), {res_gt, res_eq, res_lt}, 3'b001);
    end
    start = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cmp_seq_multibyte.md
Name: cmp_seq_multibyte

Overview:
- Sequential multi-byte magnitude comparator controller for the ALU datapath.
- Captures two BYTES-wide operands and drives one byte pair per cycle, MSB byte first, into the existing combinational 8-bit comparator (cmp_a/cmp_b).
- Consumes that comparator's gt/eq/lt outputs and stops at the first unequal byte.
- Presents registered wide-compare flags with a start/busy/done handshake.

Parameters:
BYTES, 4, operand width in bytes (>=1); operand width = 8*BYTES

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op_a  input  8*BYTES  operand A, captured on accepted start
op_b  input  8*BYTES  operand B, captured on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
res_gt  output  1  registered A > B
res_eq  output  1  registered A = B
res_lt  output  1  registered A < B
err  output  1  registered comparator-fault flag
cmp_a  output  8  byte of A to 8-bit comparator
cmp_b  output  8  byte of B to 8-bit comparator
cmp_gt  input  1  comparator A>B for current byte
cmp_eq  input  1  comparator A=B for current byte
cmp_lt  input  1  comparator A<B for current byte

Behaviour:
- Reset: asynchronous, active-low. Effective immediately, including mid-operation.
  - State returns to IDLE; idx=0; capture registers cleared.
  - busy, done, res_gt, res_eq, res_lt, err all go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmp_a = cmp_b = 0x00.
  - On start=1: capture op_a/op_b, set idx=BYTES-1, go to RUN.
  - res_* and err keep their previous values until overwritten.
- RUN:
  - cmp_a/cmp_b combinationally select byte idx of the captured operands.
  - The comparator is combinational; its flags are sampled in the same cycle.
  - Flags exactly one-hot, cmp_gt or cmp_lt set: load res_gt/res_lt (others 0), err=0, go to DONE.
  - cmp_eq only, idx>0: idx decrements, stay in RUN.
  - cmp_eq only, idx=0: load res_eq=1 (others 0), err=0, go to DONE.
  - Flags not one-hot (none or multiple set): load res_*=0, err=1, go to DONE (abort).
- DONE:
  - done=1 for exactly this one cycle; unconditional return to IDLE.
  - cmp_a = cmp_b = 0x00.
- start outside IDLE (RUN, DONE) is ignored, not queued.
- Captured operands are frozen during RUN; op_a/op_b changes after acceptance have no effect.
- Latency: start accepted at edge 0 → RUN for k cycles (k = bytes examined, 1..BYTES) → done high in cycle k+1.
  - Worst case BYTES+1 cycles (all equal). Best case 2 (MSB byte differs).
- BYTES=1: a single RUN cycle; idx stays 0.
- Exactly one of res_gt/res_eq/res_lt is 1 after any completed non-error compare. All are 0 only after reset or with err=1.
- Back-to-back: start held high re-triggers on the IDLE cycle following DONE, i.e. one accepted start every k+2 cycles.

Optional Feature:
- Macro: SIGNED_CMP_EN.
- Defined: operands are two's complement. When idx=BYTES-1, bit 7 of both cmp_a and cmp_b is inverted (XOR 0x80) before driving the comparator, so the unsigned byte compare yields signed order. Lower bytes are unchanged.
- Undefined: pure unsigned compare; no inversion logic is present.

Test Plan:
- BYTES=4, A=0x12345678, B=0x12345678, start one cycle → 4 RUN cycles (cmp_a 0x12,0x34,0x56,0x78); done in cycle 5; res_eq=1, err=0.
- A=0x80000000, B=0x7FFFFFFF unsigned → 1 RUN cycle; done in cycle 2; res_gt=1. With SIGNED_CMP_EN: cmp_a=0x00, cmp_b=0xFF; res_lt=1.
- A=0x0000_00FE, B=0x0000_00FF → 4 RUN cycles; res_lt=1. Start pulsed during RUN is ignored; no second done.
- rst_n driven low in 2nd RUN cycle of an equal compare → busy, done, res_*, err read 0 immediately; next start runs a full compare normally.
- Comparator stub forces cmp_gt=cmp_lt=1 on first byte → done in cycle 2; err=1, res_*=0. A following good compare clears err.
- start held high with A=0x01000000, B=0x02000000 → done pulses every 3 cycles; res_lt=1 each time; busy low only in IDLE cycles.
